scandoubler: RTL and testbench

// Converts the core's 15 kHz RGB video (one pixel per ce_x1 strobe) into 31 kHz

---
 rtl/scandoubler.sv | 145 ++++++++++++++
 tb/tb_scandoubler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/scandoubler.sv
// Line doubler: each 15 kHz input line is captured into one half of a ping-pong
// buffer while the previously captured line is replayed twice at the full pixel clock.
module scandoubler #(
  parameter int HCNT_W  = 10,
  parameter int COLOR_W = 6
) (
  input  logic               clk_pix,
  input  logic               reset,
  input  logic               ce_x1,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  input  logic               scanlines,
  output logic               hs_out,
  output logic               vs_out,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam int DEPTH = 1 << HCNT_W;
  localparam logic [HCNT_W-1:0] HMAX    = '1;
  localparam logic [HCNT_W:0]   LEN_ONE = (HCNT_W+1)'(1);

  // Both banks live in one array; the bank bit is the address MSB.
  logic [PIX_W-1:0] line_buf [2*DEPTH];
  logic [PIX_W-1:0] rd_data;

  logic              hs_d;
  logic [HCNT_W-1:0] hin;
  logic              bank;
  logic [HCNT_W:0]   line_len;
  logic [HCNT_W-1:0] hs_w;
  logic [HCNT_W-1:0] hs_width;
  logic              vs_lat;
  logic              seen_fall;
  logic              valid;

  logic [HCNT_W-1:0] hout;
  logic              odd;
  logic [HCNT_W-1:0] hout_d;
  logic              odd_d;
  logic              vs_d;
  logic              valid_d;

  logic hs_fall;
  logic hs_rise;
  logic wrap;

  assign hs_fall = ce_x1 & hs_d & ~hs_in;
  assign hs_rise = ce_x1 & ~hs_d & hs_in;

  // line_len of 0 or 1 keeps hout parked at 0 so a degenerate line cannot run away.
  assign wrap = (line_len <= LEN_ONE) || ({1'b0, hout} >= (line_len - LEN_ONE));

  always_ff @(posedge clk_pix) begin
    if (!reset && ce_x1 && (hin != HMAX))
      line_buf[{bank, hin}] <= {r_in, g_in, b_in};
    rd_data <= line_buf[{~bank, hout}];
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      hs_d      <= 1'b1;
      hin       <= '0;
      bank      <= 1'b0;
      line_len  <= '0;
      hs_w      <= '0;
      hs_width  <= '0;
      vs_lat    <= 1'b1;
      seen_fall <= 1'b0;
      valid     <= 1'b0;
    end else if (ce_x1) begin
      hs_d <= hs_in;
      if (hin != HMAX)
        hin <= hin + 1'b1;
      // The falling-edge sample is itself the first low sample of the pulse.
      if (hs_fall)
        hs_w <= HCNT_W'(1);
      else if (!hs_in && (hs_w != HMAX))
        hs_w <= hs_w + 1'b1;
      if (hs_rise)
        hs_width <= hs_w;
      if (hs_fall) begin
        line_len  <= {1'b0, hin} + LEN_ONE;
        hin       <= '0;
        bank      <= ~bank;
        vs_lat    <= vs_in;
        seen_fall <= 1'b1;
        if (seen_fall)
          valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pix) begin
    if (reset) begin
      hout    <= '0;
      odd     <= 1'b0;
      hout_d  <= '0;
      odd_d   <= 1'b0;
      vs_d    <= 1'b1;
      valid_d <= 1'b0;
    end else begin
      if (hs_fall) begin
        hout <= '0;
        odd  <= 1'b0;
      end else if (wrap) begin
        hout <= '0;
        odd  <= 1'b1;
      end else begin
        hout <= hout + 1'b1;
      end
      // Delay everything that qualifies the pixel by the RAM read latency.
      hout_d  <= hout;
      odd_d   <= odd;
      vs_d    <= vs_lat;
      valid_d <= valid;
    end
  end

  always_comb begin
    hs_out = 1'b1;
    vs_out = vs_d;
    r_out  = '0;
    g_out  = '0;
    b_out  = '0;
    if (valid_d) begin
      hs_out = ~(hout_d < hs_width);
      if (odd_d && scanlines) begin
        r_out = rd_data[PIX_W-1 -: COLOR_W] >> 1;
        g_out = rd_data[2*COLOR_W-1 -: COLOR_W] >> 1;
        b_out = rd_data[COLOR_W-1:0] >> 1;
      end else begin
        r_out = rd_data[PIX_W-1 -: COLOR_W];
        g_out = rd_data[2*COLOR_W-1 -: COLOR_W];
        b_out = rd_data[COLOR_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_scandoubler.sv
// Bench for scandoubler: random video lines against a line-level reference model
// that predicts every output cycle from captured lines and sync timing.
module tb_scandoubler;

  localparam int HCNT_W  = 10;
  localparam int COLOR_W = 6;
  localparam int PIX_W   = 3 * COLOR_W;
  localparam int DEPTH   = 1 << HCNT_W;

  logic clk_pix = 1'b0;
  logic reset = 1'b1;
  logic ce_x1 = 1'b0;
  logic hs_in = 1'b1;
  logic vs_in = 1'b1;
  logic scanlines = 1'b0;
  logic [COLOR_W-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic hs_out, vs_out;
  logic [COLOR_W-1:0] r_out, g_out, b_out;

  scandoubler #(.HCNT_W(HCNT_W), .COLOR_W(COLOR_W)) dut (
    .clk_pix(clk_pix), .reset(reset), .ce_x1(ce_x1), .hs_in(hs_in), .vs_in(vs_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .scanlines(scanlines),
    .hs_out(hs_out), .vs_out(vs_out), .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  // clock / reset
  always #5 clk_pix = ~clk_pix;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // reference model state
  logic [PIX_W-1:0] cur_pix [DEPTH];
  logic [PIX_W-1:0] done_pix [DEPTH];
  bit cur_ok [DEPTH];
  bit done_ok [DEPTH];
  int cur_cnt = 0;
  int done_len = 0;
  int last_fall = -10;
  int falls = 0;
  int valid_from = -1;
  bit prev_hs = 1'b1;
  int hsw_cnt = 0;
  int hsw_m = 0;
  bit vs_exp = 1'b1;
  bit vs_pend = 1'b0;
  bit vs_pend_val = 1'b1;
  int vs_pend_at = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs === exp_v) passed++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
  endtask

  function automatic logic [PIX_W-1:0] dim(input logic [PIX_W-1:0] p);
    logic [COLOR_W-1:0] r, g, b;
    r = p[PIX_W-1 -: COLOR_W] / 2;
    g = p[2*COLOR_W-1 -: COLOR_W] / 2;
    b = p[COLOR_W-1:0] / 2;
    return {r, g, b};
  endfunction

  // scoreboard: predicted output for the current cycle
  task automatic check_outputs();
    int n, len, k;
    bit odd;
    logic [PIX_W-1:0] p;
    if (vs_pend && cyc >= vs_pend_at) begin
      vs_exp = vs_pend_val;
      vs_pend = 1'b0;
    end
    check("vs_out", 32'(vs_out), 32'(vs_exp));
    if (valid_from < 0 || cyc < valid_from) begin
      check("blank_rgb", 32'({r_out, g_out, b_out}), 32'd0);
      check("blank_hs", 32'(hs_out), 32'd1);
    end else if (cyc >= last_fall + 2) begin
      n = cyc - last_fall - 2;
      len = (done_len < 1) ? 1 : done_len;
      k = n % len;
      odd = (n >= len);
      check("hs_out", 32'(hs_out), 32'(k >= hsw_m));
      if (done_ok[k]) begin
        p = done_pix[k];
        if (odd && scanlines) p = dim(p);
        check(odd ? "rgb_copy1" : "rgb_copy0", 32'({r_out, g_out, b_out}), 32'(p));
      end
    end
  endtask

  task automatic model_update(input bit rst, input bit ce, input bit hs, input bit vs,
                              input logic [PIX_W-1:0] pix);
    bit fall, rise;
    if (rst) begin
      cur_cnt = 0;
      foreach (cur_ok[i]) cur_ok[i] = 1'b0;
      falls = 0;
      valid_from = -1;
      last_fall = -10;
      prev_hs = 1'b1;
      hsw_cnt = 0;
      hsw_m = 0;
      vs_exp = 1'b1;
      vs_pend = 1'b0;
      return;
    end
    if (!ce) return;
    fall = prev_hs && !hs;
    rise = !prev_hs && hs;
    if (cur_cnt < DEPTH - 1) begin
      cur_pix[cur_cnt] = pix;
      cur_ok[cur_cnt] = 1'b1;
    end
    if (fall) begin
      done_len = cur_cnt + 1;
      done_pix = cur_pix;
      done_ok = cur_ok;
      foreach (cur_ok[i]) cur_ok[i] = 1'b0;
      cur_cnt = 0;
      last_fall = cyc;
      falls++;
      if (falls == 2) valid_from = cyc + 2;
      vs_pend = 1'b1;
      vs_pend_val = vs;
      vs_pend_at = cyc + 2;
      hsw_cnt = 1;
    end else begin
      if (cur_cnt < DEPTH - 1) cur_cnt++;
      if (!hs && hsw_cnt < DEPTH - 1) hsw_cnt++;
    end
    if (rise) hsw_m = hsw_cnt;
    prev_hs = hs;
  endtask

  // driver: one clock per call, checks then drives at the falling edge
  task automatic step(input bit rst, input bit ce, input bit hs, input bit vs,
                      input logic [PIX_W-1:0] pix);
    @(negedge clk_pix);
    if (cyc >= 1) check_outputs();
    reset = rst;
    ce_x1 = ce & ~rst;
    hs_in = hs;
    vs_in = vs;
    {r_in, g_in, b_in} = pix;
    model_update(rst, ce & ~rst, hs, vs, pix);
    cyc++;
  endtask

  task automatic send_line(input int npix, input int hs_low, input bit vs,
                           input int jitter_pct, input int fixed);
    logic [PIX_W-1:0] pix;
    bit hs;
    for (int i = 0; i < npix; i++) begin
      hs = (i >= hs_low);
      pix = (fixed >= 0) ? PIX_W'(fixed) : PIX_W'($urandom);
      if (jitter_pct > 0 && $urandom_range(99) < jitter_pct)
        step(0, 0, hs, vs, PIX_W'($urandom));
      step(0, 1, hs, vs, pix);
      step(0, 0, hs, vs, PIX_W'($urandom));
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 1, 1, '0);
  endtask

  initial begin
    do_reset(3);

    // basic doubling, 448-pixel lines with 32-pixel sync
    for (int i = 0; i < 4; i++) send_line(448, 32, 1, 0, -1);

    // scanline dimming on a full-scale colour, then on random data
    scanlines = 1'b1;
    for (int i = 0; i < 3; i++) send_line(448, 32, 1, 0, 18'h3FFFF);
    for (int i = 0; i < 2; i++) send_line(448, 32, 1, 0, -1);
    scanlines = 1'b0;

    // vsync low for three input lines
    for (int i = 0; i < 3; i++) send_line(448, 32, 0, 0, -1);
    for (int i = 0; i < 3; i++) send_line(448, 32, 1, 0, -1);

    // overlong line saturates the write counter
    send_line(1100, 32, 1, 0, -1);
    for (int i = 0; i < 3; i++) send_line(448, 32, 1, 0, -1);

    // reset in the middle of a line, then recovery
    send_line(200, 32, 1, 0, -1);
    do_reset(2);
    for (int i = 0; i < 4; i++) send_line(448, 32, 1, 0, -1);

    // missing strobes, varying sync width, and very short lines
    scanlines = 1'b1;
    for (int i = 0; i < 4; i++)
      send_line($urandom_range(300, 460), $urandom_range(8, 40), 1, 20, -1);
    for (int i = 0; i < 6; i++) send_line(2, 1, 1, 0, -1);
    for (int i = 0; i < 3; i++) send_line(64, 4, 1, 10, -1);
    scanlines = 1'b0;
    for (int i = 0; i < 2; i++) send_line(448, 32, 1, 0, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
